spi_rx_axi_slave: RTL

AXI4-lite slave that receives the 3-wire SPI stream (CEB, SCLK, DATA) driven by the SoC's SPI master port and exposes it to bus masters. Oversamples SCLK on the system clock, deserializes MSB-first 32-bit words into a FIFO, and offers data/status/control registers. Serves as the SPI receiver when two SoC instances are chained, and as the loopback checker for the SPI master slave-port.

---
 rtl/spi_rx_axi_slave.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_rx_axi_slave.sv
// 3-wire SPI receiver with AXI4-lite register access.
// SCLK is oversampled on CLK; MSB-first 32-bit words are buffered in a FIFO.
module spi_rx_axi_slave #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CEB,
    input  logic        SCLK,
    input  logic        DATA,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [31:0] axi_araddr,
    input  logic [2:0]  axi_arprot,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] axi_rdata,
    output logic        IRQ
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic          r_ceb_s1, r_ceb_s2;
    logic          r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic          r_data_s1, r_data_s2;
    logic          r_armed;
    logic [31:0]   r_shift;
    logic [4:0]    r_bitcnt;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf, r_ferr;
    logic          r_awready, r_bvalid, r_arready, r_rvalid, r_irq;
    logic [31:0]   r_rdata;

    logic          w_rise, w_shift_en, w_push, w_push_ok, w_drop, w_pop;
    logic          w_wr_fire, w_rd_fire, w_flush, w_clr, w_empty, w_full;
    logic [31:0]   w_word, w_status, w_rd_val;
    logic [CW-1:0] w_count_next;
    logic          w_unused;

    assign w_unused = ^{axi_awprot, axi_arprot, axi_wstrb, axi_awaddr[31:2],
                        axi_araddr[31:2], axi_wdata[31:2], r_shift[31]};

    // Receive only after CEB has been seen high, so reset values never fake an edge or a frame.
    assign w_rise     = r_sclk_s2 & ~r_sclk_s3;
    assign w_shift_en = w_rise & ~r_ceb_s2 & r_armed;
    assign w_push     = w_shift_en & (r_bitcnt == 5'd31);
    assign w_word     = {r_shift[30:0], r_data_s2};

    assign w_wr_fire = r_awready & axi_awvalid & axi_wvalid;
    assign w_rd_fire = r_arready & axi_arvalid;
    assign w_flush   = w_wr_fire & (axi_awaddr[1:0] == 2'd2) & axi_wdata[0];
    assign w_clr     = w_wr_fire & (axi_awaddr[1:0] == 2'd2) & axi_wdata[1];

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = w_rd_fire & (axi_araddr[1:0] == 2'd0) & ~w_empty;
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;
    assign w_status  = {16'd0, 8'(r_count), 4'd0, r_ferr, r_ovf, w_full, w_empty};

    always_comb begin
        w_rd_val = 32'd0;
        case (axi_araddr[1:0])
            2'd0:    w_rd_val = w_empty ? 32'd0 : r_mem[r_rptr];
            2'd1:    w_rd_val = w_status;
            default: w_rd_val = 32'd0;
        endcase
    end

    // Flush overrides any same-cycle push or pop.
    always_comb begin
        w_count_next = r_count;
        if (w_flush)
            w_count_next = '0;
        else if (w_push_ok && !w_pop)
            w_count_next = r_count + CW'(1);
        else if (w_pop && !w_push_ok)
            w_count_next = r_count - CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (w_push_ok && !w_flush)
            r_mem[r_wptr] <= w_word;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ceb_s1  <= 1'b0;
            r_ceb_s2  <= 1'b0;
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_data_s1 <= 1'b0;
            r_data_s2 <= 1'b0;
            r_armed   <= 1'b0;
            r_shift   <= 32'd0;
            r_bitcnt  <= 5'd0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_ferr    <= 1'b0;
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
            r_irq     <= 1'b0;
        end else begin
            r_ceb_s1  <= CEB;
            r_ceb_s2  <= r_ceb_s1;
            r_sclk_s1 <= SCLK;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_data_s1 <= DATA;
            r_data_s2 <= r_data_s1;

            if (r_ceb_s2) begin
                r_armed  <= 1'b1;
                r_bitcnt <= 5'd0;
                if (r_bitcnt != 5'd0)
                    r_ferr <= 1'b1;
            end else if (w_shift_en) begin
                r_shift  <= w_word;
                r_bitcnt <= r_bitcnt + 5'd1;
            end
            if (w_flush)
                r_bitcnt <= 5'd0;

            if (w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push_ok)
                    r_wptr <= r_wptr + AW'(1);
                if (w_pop)
                    r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_next;
            r_irq   <= (w_count_next != '0);

            if (w_drop && !w_flush)
                r_ovf <= 1'b1;
            if (w_clr) begin
                r_ovf  <= 1'b0;
                r_ferr <= 1'b0;
            end

            // Write: ready pulse, effect on the handshake cycle, then response.
            r_awready <= axi_awvalid & axi_wvalid & ~r_bvalid & ~r_awready;
            if (w_wr_fire)
                r_bvalid <= 1'b1;
            else if (axi_bready)
                r_bvalid <= 1'b0;

            r_arready <= axi_arvalid & ~r_rvalid & ~r_arready;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_val;
            end else if (axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign axi_awready = r_awready;
    assign axi_wready  = r_awready;
    assign axi_bvalid  = r_bvalid;
    assign axi_arready = r_arready;
    assign axi_rvalid  = r_rvalid;
    assign axi_rdata   = r_rdata;
    assign IRQ         = r_irq;
endmodule
